// File: rtl/xc_malu_pkg.sv
// Shared definitions for the multi-cycle ALU issue block.
// Contents: bus widths, op code constants, uop bit indices, the op code
// range that is illegal, the issue FSM state encoding and a legality helper.
package xc_malu_pkg;

  localparam int OP_W   = 4;
  localparam int PW_W   = 5;
  localparam int UOP_W  = 14;
  localparam int RS_W   = 96;
  localparam int RES_W  = 64;
  localparam int DATA_W = 32;

  // Op codes as presented on req_op.
  localparam logic [OP_W-1:0] OP_DIV    = 4'd0;
  localparam logic [OP_W-1:0] OP_DIVU   = 4'd1;
  localparam logic [OP_W-1:0] OP_REM    = 4'd2;
  localparam logic [OP_W-1:0] OP_REMU   = 4'd3;
  localparam logic [OP_W-1:0] OP_MUL    = 4'd4;
  localparam logic [OP_W-1:0] OP_MULU   = 4'd5;
  localparam logic [OP_W-1:0] OP_MULSU  = 4'd6;
  localparam logic [OP_W-1:0] OP_CLMUL  = 4'd7;
  localparam logic [OP_W-1:0] OP_PMUL   = 4'd8;
  localparam logic [OP_W-1:0] OP_PCLMUL = 4'd9;
  localparam logic [OP_W-1:0] OP_MADD   = 4'd10;
  localparam logic [OP_W-1:0] OP_MSUB   = 4'd11;
  localparam logic [OP_W-1:0] OP_MACC   = 4'd12;
  localparam logic [OP_W-1:0] OP_MMUL   = 4'd13;

  // Codes from OP_ILLEGAL_MIN up to OP_ILLEGAL_MAX have no uop.
  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd14;
  localparam logic [OP_W-1:0] OP_ILLEGAL_MAX = 4'd15;

  // Bit positions inside malu_uop; uop bit i corresponds to op code i.
  localparam int UOP_DIV    = 0;
  localparam int UOP_DIVU   = 1;
  localparam int UOP_REM    = 2;
  localparam int UOP_REMU   = 3;
  localparam int UOP_MUL    = 4;
  localparam int UOP_MULU   = 5;
  localparam int UOP_MULSU  = 6;
  localparam int UOP_CLMUL  = 7;
  localparam int UOP_PMUL   = 8;
  localparam int UOP_PCLMUL = 9;
  localparam int UOP_MADD   = 10;
  localparam int UOP_MSUB   = 11;
  localparam int UOP_MACC   = 12;
  localparam int UOP_MMUL   = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op < OP_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/xc_malu_issue_if.sv
// Bus bundle between the core, the issue block and the multi-cycle ALU.
// Groups: request (kill, req_*), ALU side (malu_*), response (rsp_*).
// slave  : view of the issue block (takes requests, drives ALU and response).
// master : view of the environment (core plus ALU model).
interface xc_malu_issue_if;
  import xc_malu_pkg::*;

  logic                kill;
  logic                req_valid;
  logic                req_ready;
  logic [OP_W-1:0]     req_op;
  logic [PW_W-1:0]     req_pw;
  logic                req_hi;
  logic [RS_W-1:0]     req_rs;

  logic                malu_valid;
  logic                malu_flush;
  logic [UOP_W-1:0]    malu_uop;
  logic [PW_W-1:0]     malu_pw;
  logic [RS_W-1:0]     malu_rs;
  logic [RES_W-1:0]    malu_result;
  logic                malu_ready;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic [RES_W-1:0]    rsp_wide;
  logic                rsp_err;

  modport slave (
    input  kill, req_valid, req_op, req_pw, req_hi, req_rs,
    input  malu_result, malu_ready, rsp_ready,
    output req_ready, malu_valid, malu_flush, malu_uop, malu_pw, malu_rs,
    output rsp_valid, rsp_data, rsp_wide, rsp_err
  );

  modport master (
    output kill, req_valid, req_op, req_pw, req_hi, req_rs,
    output malu_result, malu_ready, rsp_ready,
    input  req_ready, malu_valid, malu_flush, malu_uop, malu_pw, malu_rs,
    input  rsp_valid, rsp_data, rsp_wide, rsp_err
  );

endinterface

// File: rtl/xc_malu_issue_decode.sv
// Combinational op decoder.
// Ports: op (in, 4) request op code; uop (out, 14) one-hot uop, all zero for
// an illegal code; legal (out, 1) op code has a uop.
module xc_malu_issue_decode
  import xc_malu_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [UOP_W-1:0] uop,
  output logic             legal
);

  always_comb begin
    uop   = '0;
    legal = op_is_legal(op);
    for (int i = 0; i < UOP_W; i++) begin
      if (op == OP_W'(i)) uop[i] = 1'b1;
    end
  end

endmodule

// File: rtl/xc_malu_issue.sv
// Issue stage for the multi-cycle ALU: accepts one request, holds it on the
// ALU interface until the ALU answers or a cycle budget expires, then holds
// the response until the consumer takes it.
// Ports: clock, reset (async, active-high); bus (xc_malu_issue_if.slave)
// carrying kill, the req_* handshake, the malu_* ALU interface and the
// rsp_* response. Parameter LAT_MAX: last BUSY counter value at which a
// late malu_ready is still accepted before the operation times out.
module xc_malu_issue
  import xc_malu_pkg::*;
#(
  parameter int LAT_MAX = 40
) (
  input  logic           clock,
  input  logic           reset,
  xc_malu_issue_if.slave bus
);

  localparam int CNT_W = $clog2(LAT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAT_MAX);

  state_e            state_q, state_d;
  logic [UOP_W-1:0]  uop_q,   uop_d;
  logic [PW_W-1:0]   pw_q,    pw_d;
  logic              hi_q,    hi_d;
  logic [RS_W-1:0]   rs_q,    rs_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [RES_W-1:0]  wide_q,  wide_d;
  logic              err_q,   err_d;
  logic              flush_q, flush_d;

  logic [UOP_W-1:0]  dec_uop;
  logic              dec_legal;
  logic              req_ready;
  logic              busy;
  logic              done;

  xc_malu_issue_decode u_decode (
    .op    (bus.req_op),
    .uop   (dec_uop),
    .legal (dec_legal)
  );

  // reset is folded in so req_ready stays low until reset is released.
  assign req_ready = (state_q == ST_IDLE) && !bus.kill && !reset;
  assign busy      = (state_q == ST_BUSY);
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    uop_d   = uop_q;
    pw_d    = pw_q;
    hi_d    = hi_q;
    rs_d    = rs_q;
    cnt_d   = cnt_q;
    wide_d  = wide_q;
    err_d   = err_q;
    flush_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready) begin
          uop_d  = dec_uop;
          pw_d   = bus.req_pw;
          hi_d   = bus.req_hi;
          rs_d   = bus.req_rs;
          cnt_d  = '0;
          wide_d = '0;
          // An illegal op skips the ALU and answers with an error directly.
          err_d   = !dec_legal;
          state_d = dec_legal ? ST_BUSY : ST_DONE;
        end
      end

      ST_BUSY: begin
        if (bus.kill) begin
          flush_d = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.malu_ready) begin
          // A result arriving on the last budgeted cycle still wins.
          wide_d  = bus.malu_result;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          flush_d = 1'b1;
          wide_d  = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Handing off and accepting a new request never share a cycle:
        // req_ready only rises once the state is back in IDLE.
        if (bus.kill || bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      uop_q   <= '0;
      pw_q    <= '0;
      hi_q    <= 1'b0;
      rs_q    <= '0;
      cnt_q   <= '0;
      wide_q  <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      pw_q    <= pw_d;
      hi_q    <= hi_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      wide_q  <= wide_d;
      err_q   <= err_d;
      flush_q <= flush_d;
    end
  end

  // ALU side is quiet outside BUSY so a stale latch never looks like work.
  assign bus.req_ready  = req_ready;
  assign bus.malu_valid = busy;
  assign bus.malu_flush = flush_q;
  assign bus.malu_uop   = busy ? uop_q : '0;
  assign bus.malu_pw    = busy ? pw_q  : '0;
  assign bus.malu_rs    = busy ? rs_q  : '0;

  assign bus.rsp_valid  = done;
  assign bus.rsp_err    = done & err_q;
  assign bus.rsp_wide   = done ? wide_q : '0;
  assign bus.rsp_data   = !done ? '0 :
                          (hi_q ? wide_q[RES_W-1:DATA_W] : wide_q[DATA_W-1:0]);

endmodule

// File: doc/xc_malu_issue.md
XC_MALU_ISSUE -- requirements
Module: xc_malu_issue

Interface
REQ-001 Parameter LAT_MAX, default 40, max cycles the block waits for malu_ready before timing out.
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 kill  in  1  pipeline flush; abandons any in-flight operation.
REQ-005 req_valid  in  1  request presented.
REQ-006 req_ready  out  1  request accepted this cycle when req_valid also high.
REQ-007 req_op  in  4  op code, 0..13 = div,divu,rem,remu,mul,mulu,mulsu,clmul,pmul,pclmul,madd,msub,macc,mmul; 14..15 illegal.
REQ-008 req_pw  in  5  packed width one-hot {pw_2,pw_4,pw_8,pw_16,pw_32}.
REQ-009 req_hi  in  1  select upper result half for rsp_data.
REQ-010 req_rs  in  96  operands {rs3,rs2,rs1}.
REQ-011 malu_valid  out  1  operation valid to multi-cycle ALU.
REQ-012 malu_flush  out  1  one-cycle flush pulse to multi-cycle ALU.
REQ-013 malu_uop  out  14  one-hot uop, bit i = op i.
REQ-014 malu_pw  out  5  latched pack width.
REQ-015 malu_rs  out  96  latched operands {rs3,rs2,rs1}.
REQ-016 malu_result  in  64  ALU result, valid only while malu_ready high.
REQ-017 malu_ready  in  1  ALU result valid this cycle.
REQ-018 rsp_valid  out  1  response held.
REQ-019 rsp_ready  in  1  consumer accepts response.
REQ-020 rsp_data  out  32  selected half of captured result.
REQ-021 rsp_wide  out  64  full captured 64-bit result.
REQ-022 rsp_err  out  1  response is illegal-op or timeout; data zero.

Function
REQ-023 States IDLE, BUSY, DONE; req_ready = (state==IDLE) && !kill.
REQ-024 IDLE: on req_valid&&req_ready latch op, pw, hi, rs; legal op -> BUSY, illegal op -> DONE with rsp_err=1.
REQ-025 BUSY: malu_valid=1, malu_uop/pw/rs driven from latches, held stable every BUSY cycle; 0 outside BUSY.
REQ-026 BUSY: cycle counter starts at 0 on entry, increments each BUSY cycle.
REQ-027 BUSY with malu_ready=1: capture malu_result into rsp_wide, go DONE, rsp_err=0; malu_ready beats timeout in the same cycle.
REQ-028 BUSY with counter==LAT_MAX and malu_ready=0: malu_flush pulse next cycle, go DONE, rsp_err=1, rsp_wide=0.
REQ-029 rsp_data = hi ? rsp_wide[63:32] : rsp_wide[31:0].
REQ-030 DONE: rsp_valid=1, outputs stable; on rsp_ready -> IDLE; no new request accepted in the same cycle.
REQ-031 Latency: accept edge N, malu_valid high from N+1; malu_ready at edge M gives rsp_valid from M+1.
REQ-032 kill in BUSY: malu_flush=1 next cycle, state -> IDLE, no response; kill in DONE: response dropped, -> IDLE; kill in IDLE: no effect beyond req_ready=0.
REQ-033 malu_ready outside BUSY is ignored.

Reset
REQ-034 reset forces IDLE; counter, latches, rsp_wide, rsp_err = 0; all outputs 0 except req_ready, which becomes 1 after reset deasserts.
REQ-035 reset mid-BUSY aborts with no response; the ALU is reset by its own reset.

Structure
REQ-036 Package xc_malu_pkg holds op code constants, uop bit indices, FSM state encoding and the OP_ILLEGAL range.
REQ-037 One combinational sub-module xc_malu_issue_decode maps req_op to malu_uop one-hot and a legal flag.

Verification
REQ-038 mul op=4, rs1=7, rs2=6, hi=0; model ready after 3 cycles with result 42 -> rsp_data=42, rsp_valid on the cycle after ready.
REQ-039 divu op=1, hi=1; model result 0x00000003_00000002 -> rsp_data=3, rsp_wide=0x0000000300000002, rsp_err=0.
REQ-040 op=14 -> rsp_valid one cycle after accept, rsp_err=1, malu_valid never asserted.
REQ-041 LAT_MAX=40, model never ready -> malu_flush pulse, rsp_err=1 after 41 BUSY cycles; separately, ready on cycle 40 -> success.
REQ-042 kill in the 2nd BUSY cycle -> malu_flush pulse, no rsp_valid, next request accepted normally.
REQ-043 rsp_ready held low 5 cycles -> rsp_data stable and req_ready=0 throughout; async reset asserted mid-BUSY -> all outputs 0 immediately.
